mem_sram_responder: RTL

- Memory-side slave for the core's generic req/gnt/rvalid memory interface. It sits directly downstream of a master driving that interface.
- Grants requests and performs byte-enabled writes and reads on an internal word array. Returns exactly one in-order response per granted request after a fixed latency.
- Used as the backing store in core-level simulation and as the reference responder for interface verification.

---
 rtl/mem_sram_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_sram_responder.sv
// mem_sram_responder
// ------------------
// Memory-side slave for the generic req/gnt/rvalid memory interface. Grants
// requests, performs byte-enabled writes and reads on an internal word array,
// and returns exactly one in-order response per granted request a fixed
// LATENCY cycles after the grant.
//
// Handshake: a request transfers in any cycle where data_req and data_gnt are
// both high (data_gnt is combinational on data_req). The master holds
// address/data_wdata/data_we/data_be stable while data_req is high and
// data_gnt is low. Responses have no backpressure: data_rvalid is a one-cycle
// pulse that the master must always consume.
//
// Ports:
//   clk_i          clock, all logic on posedge
//   rst_i          synchronous active-high reset
//   address        request byte address (word index = address[OFF +: IDX])
//   data_wdata     write data
//   data_req       request valid
//   data_we        1 = write, 0 = read
//   data_be        byte enables (writes only)
//   data_gnt       request accepted this cycle
//   data_rvalid    response valid pulse
//   data_rdata     read data (0 for write responses, holds outside rvalid)
//   stall_i        blocks new grants
//   outstanding_o  granted-but-unanswered request count
module mem_sram_responder #(
  parameter int ADDRESS_SIZE    = 64,
  parameter int DATA_WIDTH      = 64,
  parameter int NUM_WORDS       = 256,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic [ADDRESS_SIZE-1:0]                  address,
  input  logic [DATA_WIDTH-1:0]                    data_wdata,
  input  logic                                     data_req,
  input  logic                                     data_we,
  input  logic [DATA_WIDTH/8-1:0]                  data_be,
  output logic                                     data_gnt,
  output logic                                     data_rvalid,
  output logic [DATA_WIDTH-1:0]                    data_rdata,
  input  logic                                     stall_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BE_W);
  localparam int IDX   = $clog2(NUM_WORDS);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // Word array; deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];

  // Response pipeline: stage LATENCY-1 drives the outputs directly.
  logic [LATENCY-1:0]    valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q [LATENCY];
  logic [DATA_WIDTH-1:0] data_d [LATENCY];
  logic [OUT_W-1:0]      outstanding_q, outstanding_d;

  logic [IDX-1:0] word_idx;
  logic           retire;
  logic           room;
  logic           gnt;

  // Offset and upper address bits are ignored, so addresses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address;

  assign word_idx = address[OFF +: IDX];

  // A response leaving this cycle frees a slot, so a full responder can
  // still grant when the oldest request retires in the same cycle.
  assign retire = valid_q[LATENCY-1];
  assign room   = (outstanding_q < OUT_W'(MAX_OUTSTANDING)) | retire;
  assign gnt    = data_req & ~stall_i & ~rst_i & room;

  always_comb begin
    valid_d = '0;
    for (int i = 0; i < LATENCY; i++) begin
      data_d[i] = '0;
    end

    // Stage 0 captures the word at the grant edge; writes answer with zero.
    valid_d[0] = gnt;
    data_d[0]  = (gnt && !data_we) ? mem_q[word_idx] : '0;

    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end

    // The output stage only loads on a real response so data_rdata holds
    // its last value between pulses.
    if (!valid_d[LATENCY-1]) begin
      data_d[LATENCY-1] = data_q[LATENCY-1];
    end

    outstanding_d = outstanding_q;
    if (gnt && !retire) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!gnt && retire) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q       <= valid_d;
      outstanding_q <= outstanding_d;
      for (int i = 0; i < LATENCY; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // gnt is already low during reset, so in-flight writes are never lost and
  // no new write lands while reset is asserted.
  always_ff @(posedge clk_i) begin
    if (gnt && data_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (data_be[k]) begin
          mem_q[word_idx][k*8 +: 8] <= data_wdata[k*8 +: 8];
        end
      end
    end
  end

  assign data_gnt      = gnt;
  assign data_rvalid   = valid_q[LATENCY-1];
  assign data_rdata    = data_q[LATENCY-1];
  assign outstanding_o = outstanding_q;

endmodule
